sdp_pipe: RTL and testbench

//   Parametrised simple-dual-port RAM with valid/ready write and read ports.

---
 rtl/sdp_pipe_if.sv | 39 +++
 rtl/sdp_pipe.sv | 142 ++++++++++++++
 tb/tb_sdp_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdp_pipe_if.sv
// sdp_pipe_if: handshake bundle for the sdp_pipe RAM.
//   Write port : wr_addr_data_{valid,ready,data}; data = {be, data, addr}, addr in LSBs
//   Read addr  : rd_addr_{valid,ready,data}
//   Read data  : rd_data_{valid,ready,data}
//   master = requester/consumer side, slave = RAM side.
interface sdp_pipe_if #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 10
);
  localparam int W_BE = W_DATA / 8;

  logic                          wr_addr_data_ready;
  logic                          wr_addr_data_valid;
  logic [W_BE+W_DATA+W_ADDR-1:0] wr_addr_data_data;
  logic                          rd_addr_ready;
  logic                          rd_addr_valid;
  logic [W_ADDR-1:0]             rd_addr_data;
  logic                          rd_data_ready;
  logic                          rd_data_valid;
  logic [W_DATA-1:0]             rd_data_data;

  modport master (
    input  wr_addr_data_ready,
    output wr_addr_data_valid, wr_addr_data_data,
    input  rd_addr_ready,
    output rd_addr_valid, rd_addr_data,
    output rd_data_ready,
    input  rd_data_valid, rd_data_data
  );

  modport slave (
    output wr_addr_data_ready,
    input  wr_addr_data_valid, wr_addr_data_data,
    output rd_addr_ready,
    input  rd_addr_valid, rd_addr_data,
    input  rd_data_ready,
    output rd_data_valid, rd_data_data
  );
endinterface

// File: rtl/sdp_pipe.sv
// sdp_pipe: simple-dual-port RAM with byte strobes, READ_LATENCY-cycle read pipeline,
// selectable read-during-write behaviour and a credit-limited output FIFO.
//   clk  : clock
//   rst  : synchronous reset, active-high (RAM contents are kept)
//   bus  : sdp_pipe_if.slave (write port, read address port, read data port)
module sdp_pipe #(
  parameter int W_DATA       = 32,
  parameter int W_ADDR       = 10,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2,
  parameter int COLLISION    = 0
) (
  input  logic      clk,
  input  logic      rst,
  sdp_pipe_if.slave bus
);
  localparam int W_BE    = W_DATA / 8;
  localparam int CREDITS = READ_LATENCY + 1;
  localparam int CNT_W   = $clog2(CREDITS + 1);
  localparam int PTR_W   = $clog2(CREDITS);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [W_ADDR:0] DEPTH_L = (W_ADDR + 1)'(DEPTH);

  logic [W_DATA-1:0] mem_q [DEPTH];

  logic [W_ADDR-1:0] wr_addr;
  logic [W_DATA-1:0] wr_data;
  logic [W_BE-1:0]   wr_be;
  logic              wr_fire, wr_in_range;
  logic [W_ADDR-1:0] rd_addr;
  logic              rd_fire, rd_in_range, addr_rdy;
  logic [W_DATA-1:0] rd_word;

  assign wr_addr     = bus.wr_addr_data_data[W_ADDR-1:0];
  assign wr_data     = bus.wr_addr_data_data[W_ADDR +: W_DATA];
  assign wr_be       = bus.wr_addr_data_data[W_ADDR+W_DATA +: W_BE];
  assign wr_fire     = bus.wr_addr_data_valid & ~rst;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;

  assign rd_addr     = bus.rd_addr_data;
  assign rd_fire     = bus.rd_addr_valid & addr_rdy & ~rst;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;

  assign bus.wr_addr_data_ready = 1'b1;
  assign bus.rd_addr_ready      = addr_rdy;

  always_ff @(posedge clk) begin
    if (wr_fire && wr_in_range) begin
      for (int b = 0; b < W_BE; b++) begin
        if (wr_be[b]) mem_q[wr_addr[IDX_W-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // The array still holds the pre-write word during the write cycle, so READ_FIRST
  // falls out naturally; WRITE_FIRST overlays the strobed lanes of the incoming write.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem_q[rd_addr[IDX_W-1:0]];
    if (COLLISION != 0 && wr_fire && wr_in_range && wr_addr == rd_addr) begin
      for (int b = 0; b < W_BE; b++) begin
        if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // The FIFO write is the last pipeline stage, so READ_LATENCY-1 registers precede it.
  logic              push_vld;
  logic [W_DATA-1:0] push_data;

  if (READ_LATENCY == 1) begin : g_bare
    assign push_vld  = rd_fire;
    assign push_data = rd_word;
  end else begin : g_pipe
    localparam int N = READ_LATENCY - 1;
    logic              vld_q  [N];
    logic [W_DATA-1:0] data_q [N];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < N; i++) vld_q[i] <= 1'b0;
      end else begin
        vld_q[0] <= rd_fire;
        for (int i = 1; i < N; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      data_q[0] <= rd_word;
      for (int i = 1; i < N; i++) data_q[i] <= data_q[i-1];
    end

    assign push_vld  = vld_q[N-1];
    assign push_data = data_q[N-1];
  end

  // Credits cover pipeline plus FIFO, so the FIFO (depth CREDITS) can never overflow.
  logic [W_DATA-1:0] fifo_q [CREDITS];
  logic [CNT_W-1:0]  cnt_q, cnt_d, occ_q, occ_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CREDITS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign addr_rdy          = cnt_q < CNT_W'(CREDITS);
  assign bus.rd_data_valid = occ_q != '0;
  assign bus.rd_data_data  = fifo_q[rd_ptr_q];
  assign pop               = bus.rd_data_valid & bus.rd_data_ready;

  always_comb begin
    cnt_d    = cnt_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (rd_fire && !pop) cnt_d = cnt_q + CNT_W'(1);
    else if (!rd_fire && pop) cnt_d = cnt_q - CNT_W'(1);
    if (push_vld && !pop) occ_d = occ_q + CNT_W'(1);
    else if (!push_vld && pop) occ_d = occ_q - CNT_W'(1);
    if (push_vld) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) fifo_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: tb/tb_sdp_pipe.sv
// tb_sdp_pipe: directed bench driving two sdp_pipe instances with identical stimulus.
//   dut0: DEPTH=1024, READ_LATENCY=2, COLLISION=0 (READ_FIRST)
//   dut1: DEPTH=1000, READ_LATENCY=2, COLLISION=1 (WRITE_FIRST), so addr 1000 is out of range
module tb_sdp_pipe;
  logic        clk;
  logic        rst;
  logic        wr_v;
  logic [45:0] wr_pl;
  logic        rd_v;
  logic [9:0]  rd_a;
  logic        rdy;
  int          n_chk;
  int          n_err;

  sdp_pipe_if #(.W_DATA(32), .W_ADDR(10)) if0 ();
  sdp_pipe_if #(.W_DATA(32), .W_ADDR(10)) if1 ();

  assign if0.wr_addr_data_valid = wr_v;
  assign if0.wr_addr_data_data  = wr_pl;
  assign if0.rd_addr_valid      = rd_v;
  assign if0.rd_addr_data       = rd_a;
  assign if0.rd_data_ready      = rdy;
  assign if1.wr_addr_data_valid = wr_v;
  assign if1.wr_addr_data_data  = wr_pl;
  assign if1.rd_addr_valid      = rd_v;
  assign if1.rd_addr_data       = rd_a;
  assign if1.rd_data_ready      = rdy;

  sdp_pipe #(.W_DATA(32), .W_ADDR(10), .DEPTH(1024), .READ_LATENCY(2), .COLLISION(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  sdp_pipe #(.W_DATA(32), .W_ADDR(10), .DEPTH(1000), .READ_LATENCY(2), .COLLISION(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_v  = 1'b1;
    wr_pl = {be, d, a};
    tick();
    wr_v  = 1'b0;
  endtask

  task automatic rd_one(input string tag, input logic [9:0] a,
                        input logic [31:0] e0, input logic [31:0] e1);
    rd_v = 1'b1;
    rd_a = a;
    rdy  = 1'b1;
    tick();
    rd_v = 1'b0;
    tick();
    chk({tag, "_v0"}, if0.rd_data_valid, 1'b1);
    chk({tag, "_v1"}, if1.rd_data_valid, 1'b1);
    chk({tag, "_d0"}, if0.rd_data_data, e0);
    chk({tag, "_d1"}, if1.rd_data_data, e1);
    tick();
  endtask

  function automatic logic [31:0] exp_word(input int j);
    return (j == 5) ? 32'hDEADBEEF : (32'h1000_0000 | 32'(j));
  endfunction

  initial begin
    int next_a;
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    wr_v  = 1'b0;
    wr_pl = '0;
    rd_v  = 1'b0;
    rd_a  = '0;
    rdy   = 1'b1;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid0", if0.rd_data_valid, 1'b0);
    chk("rst_valid1", if1.rd_data_valid, 1'b0);
    chk("rst_ready0", if0.rd_addr_ready, 1'b1);
    chk("rst_ready1", if1.rd_addr_ready, 1'b1);
    chk("wr_ready",   if0.wr_addr_data_ready, 1'b1);

    for (int i = 0; i < 16; i++) wr(10'(i), 32'h1000_0000 | 32'(i), 4'hF);
    wr(10'd5, 32'hDEADBEEF, 4'hF);

    // Latency: read presented in cycle t, data valid in cycle t+2
    rd_v = 1'b1;
    rd_a = 10'd5;
    chk("lat_t0", if0.rd_data_valid, 1'b0);
    tick();
    rd_v = 1'b0;
    chk("lat_t1", if0.rd_data_valid, 1'b0);
    tick();
    chk("lat_t2_v", if0.rd_data_valid, 1'b1);
    chk("lat_t2_d0", if0.rd_data_data, 32'hDEADBEEF);
    chk("lat_t2_d1", if1.rd_data_data, 32'hDEADBEEF);
    tick();
    chk("lat_t3", if0.rd_data_valid, 1'b0);

    // Back-to-back reads of 0..15
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        rd_v = 1'b1;
        rd_a = 10'(c);
        chk($sformatf("b2b_rdy%0d", c), if0.rd_addr_ready, 1'b1);
      end else begin
        rd_v = 1'b0;
      end
      if (c >= 2) begin
        chk($sformatf("b2b_v%0d", c), if0.rd_data_valid, 1'b1);
        chk($sformatf("b2b_d0_%0d", c), if0.rd_data_data, exp_word(c - 2));
        chk($sformatf("b2b_d1_%0d", c), if1.rd_data_data, exp_word(c - 2));
      end else begin
        chk($sformatf("b2b_v%0d", c), if0.rd_data_valid, 1'b0);
      end
      tick();
    end
    chk("b2b_idle", if0.rd_data_valid, 1'b0);

    // Back-pressure: exactly 3 reads accepted while stalled
    rdy    = 1'b0;
    next_a = 0;
    for (int c = 0; c < 6; c++) begin
      rd_v = 1'b1;
      rd_a = 10'(next_a);
      chk($sformatf("bp_rdy%0d", c), if0.rd_addr_ready, (c < 3) ? 1'b1 : 1'b0);
      chk($sformatf("bp_rdy1_%0d", c), if1.rd_addr_ready, (c < 3) ? 1'b1 : 1'b0);
      if (c >= 2) begin
        chk($sformatf("bp_hold_v%0d", c), if0.rd_data_valid, 1'b1);
        chk($sformatf("bp_hold_d%0d", c), if0.rd_data_data, exp_word(0));
      end else begin
        chk($sformatf("bp_hold_v%0d", c), if0.rd_data_valid, 1'b0);
      end
      if (if0.rd_addr_ready) next_a++;
      tick();
    end
    rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rd_v = (k <= 9);
      rd_a = 10'(next_a);
      if (k <= 9) chk($sformatf("bp_resume_rdy%0d", k), if0.rd_addr_ready, (k == 0) ? 1'b0 : 1'b1);
      chk($sformatf("bp_resume_v%0d", k), if0.rd_data_valid, 1'b1);
      chk($sformatf("bp_resume_d0_%0d", k), if0.rd_data_data, exp_word(k));
      chk($sformatf("bp_resume_d1_%0d", k), if1.rd_data_data, exp_word(k));
      if (rd_v && if0.rd_addr_ready) next_a++;
      tick();
    end
    rd_v = 1'b0;
    chk("bp_idle", if0.rd_data_valid, 1'b0);

    // Byte enables, including a be=0 no-op
    wr(10'd7, 32'h11223344, 4'hF);
    wr(10'd7, 32'hAABBCCDD, 4'b0101);
    wr(10'd7, 32'hFFFFFFFF, 4'b0000);
    rd_one("be", 10'd7, 32'h11BB33DD, 32'h11BB33DD);

    // Collision, full-word write
    wr(10'd3, 32'h1, 4'hF);
    wr_v  = 1'b1;
    wr_pl = {4'hF, 32'h2, 10'd3};
    rd_v  = 1'b1;
    rd_a  = 10'd3;
    tick();
    wr_v = 1'b0;
    tick();
    rd_v = 1'b0;
    chk("col_v",  if0.rd_data_valid, 1'b1);
    chk("col_d0", if0.rd_data_data, 32'h1);
    chk("col_d1", if1.rd_data_data, 32'h2);
    tick();
    chk("col_next_v",  if0.rd_data_valid, 1'b1);
    chk("col_next_d0", if0.rd_data_data, 32'h2);
    chk("col_next_d1", if1.rd_data_data, 32'h2);
    tick();
    chk("col_idle", if1.rd_data_valid, 1'b0);

    // Collision, partial strobe: unstrobed lanes keep old data
    wr_v  = 1'b1;
    wr_pl = {4'b0011, 32'hAABBCCDD, 10'd3};
    rd_v  = 1'b1;
    rd_a  = 10'd3;
    tick();
    wr_v = 1'b0;
    rd_v = 1'b0;
    tick();
    chk("colp_v1", if1.rd_data_valid, 1'b1);
    chk("colp_d0", if0.rd_data_data, 32'h0000_0002);
    chk("colp_d1", if1.rd_data_data, 32'h0000_CCDD);
    tick();
    rd_one("colp_after", 10'd3, 32'h0000_CCDD, 32'h0000_CCDD);

    // Out of range on dut1 only
    wr(10'd1000, 32'h55, 4'hF);
    rd_one("oor", 10'd1000, 32'h55, 32'h0);

    // Reset mid-stream, with requests presented during reset
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rd_v = 1'b1;
      rd_a = 10'(c);
      tick();
    end
    rst   = 1'b1;
    rd_a  = 10'd9;
    wr_v  = 1'b1;
    wr_pl = {4'hF, 32'h0, 10'd5};
    chk("mid_stalled_v", if0.rd_data_valid, 1'b1);
    tick();
    rst  = 1'b0;
    rd_v = 1'b0;
    wr_v = 1'b0;
    chk("mid_rst_v0", if0.rd_data_valid, 1'b0);
    chk("mid_rst_v1", if1.rd_data_valid, 1'b0);
    chk("mid_rst_rdy", if0.rd_addr_ready, 1'b1);
    rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mid_nostale0_%0d", c), if0.rd_data_valid, 1'b0);
      chk($sformatf("mid_nostale1_%0d", c), if1.rd_data_valid, 1'b0);
    end
    rd_one("mid_ram", 10'd5, 32'hDEADBEEF, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
